// File: rtl/maxpool_window_gen.sv
// Streaming 3x3 window generator for the max-pooling cell: two line buffers plus a
// two-column shift register build each neighbourhood, decimated by STRIDE.
module maxpool_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int STRIDE     = 1
) (
    input  logic                  C_IN_CLK,
    input  logic                  C_IN_RSTN,
    input  logic                  C_IN_DATA_VALID,
    input  logic [DATA_WIDTH-1:0] D_IN_DATA,
    output logic                  C_OUT_DATA_VALID,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_1,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_2,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_3,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_4,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_5,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_6,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_7,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_8,
    output logic [DATA_WIDTH-1:0] D_OUT_DATA_9,
    output logic                  C_OUT_FRAME_DONE
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [1:0]            rstSync_q;
    logic                  rstInt_n;
    logic [COL_W-1:0]      colCnt_q, colCnt_d;
    logic [ROW_W-1:0]      rowCnt_q, rowCnt_d;
    logic                  accept;
    logic                  emit;
    logic                  lastPix;
    logic                  dataValid_q;
    logic                  frameDone_q;
    logic [DATA_WIDTH-1:0] lbOld   [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lbNew   [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] colA_q  [3];
    logic [DATA_WIDTH-1:0] colB_q  [3];
    logic [DATA_WIDTH-1:0] newCol  [3];
    logic [DATA_WIDTH-1:0] winOut_q[9];

    // Reset asserts asynchronously but is released two clocks after C_IN_RSTN rises.
    always_ff @(posedge C_IN_CLK or negedge C_IN_RSTN) begin
        if (!C_IN_RSTN) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];
    assign accept   = C_IN_DATA_VALID && rstInt_n;
    assign lastPix  = (colCnt_q == COL_LAST) && (rowCnt_q == ROW_LAST);

    assign newCol[0] = lbOld[colCnt_q];
    assign newCol[1] = lbNew[colCnt_q];
    assign newCol[2] = D_IN_DATA;

    // STRIDE is 1 or 2, so the modulo test on (pos-2) reduces to an even-position check.
    assign emit = (rowCnt_q >= ROW_W'(2)) && (colCnt_q >= COL_W'(2)) &&
                  ((STRIDE == 1) || (!rowCnt_q[0] && !colCnt_q[0]));

    always_comb begin
        colCnt_d = colCnt_q;
        rowCnt_d = rowCnt_q;
        if (accept) begin
            if (colCnt_q == COL_LAST) begin
                colCnt_d = '0;
                rowCnt_d = (rowCnt_q == ROW_LAST) ? '0 : rowCnt_q + 1'b1;
            end else begin
                colCnt_d = colCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge C_IN_CLK) begin
        if (accept) begin
            lbOld[colCnt_q] <= lbNew[colCnt_q];
            lbNew[colCnt_q] <= D_IN_DATA;
        end
    end

    always_ff @(posedge C_IN_CLK or negedge rstInt_n) begin
        if (!rstInt_n) begin
            colCnt_q    <= '0;
            rowCnt_q    <= '0;
            dataValid_q <= 1'b0;
            frameDone_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                colA_q[i] <= '0;
                colB_q[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                winOut_q[k] <= '0;
            end
        end else begin
            colCnt_q    <= colCnt_d;
            rowCnt_q    <= rowCnt_d;
            dataValid_q <= accept && emit;
            frameDone_q <= accept && lastPix;
            if (accept) begin
                colA_q <= colB_q;
                colB_q <= newCol;
                if (emit) begin
                    for (int i = 0; i < 3; i++) begin
                        winOut_q[3*i]     <= colA_q[i];
                        winOut_q[3*i + 1] <= colB_q[i];
                        winOut_q[3*i + 2] <= newCol[i];
                    end
                end
            end
        end
    end

    assign C_OUT_DATA_VALID = dataValid_q;
    assign C_OUT_FRAME_DONE = frameDone_q;
    assign D_OUT_DATA_1     = winOut_q[0];
    assign D_OUT_DATA_2     = winOut_q[1];
    assign D_OUT_DATA_3     = winOut_q[2];
    assign D_OUT_DATA_4     = winOut_q[3];
    assign D_OUT_DATA_5     = winOut_q[4];
    assign D_OUT_DATA_6     = winOut_q[5];
    assign D_OUT_DATA_7     = winOut_q[6];
    assign D_OUT_DATA_8     = winOut_q[7];
    assign D_OUT_DATA_9     = winOut_q[8];

endmodule

// File: tb/tb_maxpool_window_gen.sv
// Directed bench for maxpool_window_gen: a 4x4/STRIDE=1 instance and a 5x5/STRIDE=2
// instance sharing one clock and reset.
module tb_maxpool_window_gen;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        v4 = 1'b0;
    logic        v5 = 1'b0;
    logic [31:0] d4in = '0;
    logic [31:0] d5in = '0;
    logic        ov4, fd4, ov5, fd5;
    logic [31:0] o4[9];
    logic [31:0] o5[9];
    logic [287:0] win4, win5;
    logic [287:0] lastExp4 = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .STRIDE(1)) dut4 (
        .C_IN_CLK(clk), .C_IN_RSTN(rstN), .C_IN_DATA_VALID(v4), .D_IN_DATA(d4in),
        .C_OUT_DATA_VALID(ov4),
        .D_OUT_DATA_1(o4[0]), .D_OUT_DATA_2(o4[1]), .D_OUT_DATA_3(o4[2]),
        .D_OUT_DATA_4(o4[3]), .D_OUT_DATA_5(o4[4]), .D_OUT_DATA_6(o4[5]),
        .D_OUT_DATA_7(o4[6]), .D_OUT_DATA_8(o4[7]), .D_OUT_DATA_9(o4[8]),
        .C_OUT_FRAME_DONE(fd4)
    );

    maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(2)) dut5 (
        .C_IN_CLK(clk), .C_IN_RSTN(rstN), .C_IN_DATA_VALID(v5), .D_IN_DATA(d5in),
        .C_OUT_DATA_VALID(ov5),
        .D_OUT_DATA_1(o5[0]), .D_OUT_DATA_2(o5[1]), .D_OUT_DATA_3(o5[2]),
        .D_OUT_DATA_4(o5[3]), .D_OUT_DATA_5(o5[4]), .D_OUT_DATA_6(o5[5]),
        .D_OUT_DATA_7(o5[6]), .D_OUT_DATA_8(o5[7]), .D_OUT_DATA_9(o5[8]),
        .C_OUT_FRAME_DONE(fd5)
    );

    assign win4 = {o4[0], o4[1], o4[2], o4[3], o4[4], o4[5], o4[6], o4[7], o4[8]};
    assign win5 = {o5[0], o5[1], o5[2], o5[3], o5[4], o5[5], o5[6], o5[7], o5[8]};

    function automatic logic [287:0] pack9(input int a, input int b, input int c,
                                           input int d, input int e, input int f,
                                           input int g, input int h, input int i);
        return {32'(a), 32'(b), 32'(c), 32'(d), 32'(e), 32'(f), 32'(g), 32'(h), 32'(i)};
    endfunction

    // Window whose top-left pixel has value base, in an image whose rows step by w.
    function automatic logic [287:0] winOf(input int base, input int w);
        logic [287:0] res;
        res = '0;
        for (int k = 0; k < 9; k++) begin
            res[(8-k)*32 +: 32] = 32'(base + (k/3)*w + (k%3));
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drives one cycle, returns at the next falling edge.
    task automatic applyStimulus(input int unitSel, input logic v, input logic [31:0] d);
        if (unitSel == 4) begin
            v4 = v; d4in = d; v5 = 1'b0;
        end else begin
            v5 = v; d5in = d; v4 = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic sampleUnit(input int unitSel, output logic obsV, output logic obsD,
                              output logic [287:0] obsW);
        if (unitSel == 4) begin
            obsV = ov4; obsD = fd4; obsW = win4;
        end else begin
            obsV = ov5; obsD = fd5; obsW = win5;
        end
    endtask

    task automatic runFrame(input int unitSel, input int offset, input bit gapped,
                            output int pulses, output int dones,
                            output logic [287:0] firstWin, output logic [287:0] secondWin,
                            output logic [287:0] lastWin);
        int w, h, st, seen;
        logic expV, expD, obsV, obsD;
        logic [287:0] obsW, expW;
        w = (unitSel == 4) ? 4 : 5;
        h = w;
        st = (unitSel == 4) ? 1 : 2;
        pulses = 0; dones = 0; seen = 0;
        firstWin = '0; secondWin = '0; lastWin = '0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                applyStimulus(unitSel, 1'b1, 32'(offset + r*w + c));
                sampleUnit(unitSel, obsV, obsD, obsW);
                expV = (r >= 2) && (c >= 2) && (((r-2) % st) == 0) && (((c-2) % st) == 0);
                expD = (r == h-1) && (c == w-1);
                checkOutput($sformatf("u%0d_valid_r%0dc%0d", unitSel, r, c), 288'(obsV), 288'(expV));
                checkOutput($sformatf("u%0d_done_r%0dc%0d", unitSel, r, c), 288'(obsD), 288'(expD));
                if (expV) begin
                    expW = winOf(offset + (r-2)*w + (c-2), w);
                    checkOutput($sformatf("u%0d_win_r%0dc%0d", unitSel, r, c), obsW, expW);
                    if (unitSel == 4) lastExp4 = expW;
                end
                if (obsV) begin
                    pulses++;
                    if (seen == 0) firstWin = obsW;
                    else if (seen == 1) secondWin = obsW;
                    lastWin = obsW;
                    seen++;
                end
                if (obsD) dones++;
                if (gapped) begin
                    applyStimulus(unitSel, 1'b0, 32'hDEAD_BEEF);
                    sampleUnit(unitSel, obsV, obsD, obsW);
                    checkOutput($sformatf("u%0d_idle_valid_r%0dc%0d", unitSel, r, c), 288'(obsV), 288'(0));
                    checkOutput($sformatf("u%0d_idle_done_r%0dc%0d", unitSel, r, c), 288'(obsD), 288'(0));
                    checkOutput($sformatf("u%0d_idle_hold_r%0dc%0d", unitSel, r, c), obsW, lastExp4);
                end
            end
        end
    endtask

    initial begin
        int p, dn, p2, dn2;
        logic [287:0] fw, sw, lw, fw2, sw2, lw2;

        $display("[TB] start");
        @(negedge clk);
        checkOutput("rst_valid4", 288'(ov4), 288'(0));
        checkOutput("rst_done4", 288'(fd4), 288'(0));
        checkOutput("rst_win4", win4, '0);
        checkOutput("rst_valid5", 288'(ov5), 288'(0));

        rstN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4, 1'b0, 32'h0);
            checkOutput("release_valid4", 288'(ov4), 288'(0));
        end

        $display("[TB] 4x4 stride 1 continuous");
        runFrame(4, 0, 1'b0, p, dn, fw, sw, lw);
        checkOutput("t1_pulses", 288'(p), 288'(4));
        checkOutput("t1_dones", 288'(dn), 288'(1));
        checkOutput("t1_first", fw, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        checkOutput("t1_last", lw, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        $display("[TB] 5x5 stride 2");
        runFrame(5, 0, 1'b0, p, dn, fw, sw, lw);
        checkOutput("t2_pulses", 288'(p), 288'(4));
        checkOutput("t2_dones", 288'(dn), 288'(1));
        checkOutput("t2_first", fw, pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        checkOutput("t2_second", sw, pack9(2, 3, 4, 7, 8, 9, 12, 13, 14));
        checkOutput("t2_last", lw, pack9(12, 13, 14, 17, 18, 19, 22, 23, 24));
        checkOutput("t2_hold4", win4, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        $display("[TB] 4x4 gapped valid");
        runFrame(4, 0, 1'b1, p, dn, fw, sw, lw);
        checkOutput("t3_pulses", 288'(p), 288'(4));
        checkOutput("t3_first", fw, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        checkOutput("t3_last", lw, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        $display("[TB] two back-to-back frames");
        runFrame(4, 0, 1'b0, p, dn, fw, sw, lw);
        runFrame(4, 100, 1'b0, p2, dn2, fw2, sw2, lw2);
        checkOutput("t4_pulses", 288'(p + p2), 288'(8));
        checkOutput("t4_dones", 288'(dn + dn2), 288'(2));
        checkOutput("t4_first2", fw2, pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));

        $display("[TB] mid-frame reset");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4, 1'b1, 32'(200 + i));
            checkOutput($sformatf("t5_pre_valid_%0d", i), 288'(ov4), 288'(0));
        end
        checkOutput("t5_pre_hold", win4, pack9(105, 106, 107, 109, 110, 111, 113, 114, 115));
        #2 rstN = 1'b0;
        v4 = 1'b1; d4in = 32'h0BAD_0BAD;
        #1;
        checkOutput("t5_rst_valid", 288'(ov4), 288'(0));
        checkOutput("t5_rst_done", 288'(fd4), 288'(0));
        checkOutput("t5_rst_win", win4, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_inrst_valid_%0d", i), 288'(ov4), 288'(0));
        end
        rstN = 1'b1;
        lastExp4 = '0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4, 1'b0, 32'h0);
            checkOutput($sformatf("t5_release_valid_%0d", i), 288'(ov4), 288'(0));
            checkOutput($sformatf("t5_release_win_%0d", i), win4, '0);
        end
        runFrame(4, 0, 1'b0, p, dn, fw, sw, lw);
        checkOutput("t5_pulses", 288'(p), 288'(4));
        checkOutput("t5_dones", 288'(dn), 288'(1));
        checkOutput("t5_first", fw, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        checkOutput("t5_last", lw, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        applyStimulus(4, 1'b0, 32'h0);
        checkOutput("end_idle_valid", 288'(ov4), 288'(0));
        checkOutput("end_idle_hold", win4, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
